// File: rtl/ddot_issue_ctrl.sv
// Feeder for the iterative dot-product engine: double-buffered vector load, whole-vector burst
// issue gated by result credits, and an in-order result FIFO with a valid/ack drain.
module ddot_issue_ctrl #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned VLEN         = 8,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned RES_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_x_i,
    input  logic [31:0]          in_y_i,
    output logic                 eng_ready_o,
    output logic [LANES*32-1:0]  eng_x_o,
    output logic [LANES*32-1:0]  eng_y_o,
    input  logic                 eng_vld_i,
    input  logic [31:0]          eng_z_i,
    output logic                 res_valid_o,
    output logic [31:0]          res_data_o,
    input  logic                 res_ack_i
);
    localparam int unsigned BEATS = VLEN / LANES;
    localparam int unsigned IW    = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CW    = $clog2(RES_DEPTH + 1);
    localparam int unsigned PW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    logic [31:0]          x_mem_q [2][VLEN];
    logic [31:0]          y_mem_q [2][VLEN];
    logic                 wr_bank_q, wr_bank_d;
    logic [IW-1:0]        wr_idx_q, wr_idx_d;
    logic [1:0]           full_q, full_d;
    logic                 in_fire;

    state_e               state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic                 credit_ok, last_beat, issue_idle, issue_next, issue;
    logic [IW-1:0]        base_idx;

    logic                 eng_ready_q, eng_ready_d;
    logic [LANES*32-1:0]  eng_x_q, eng_x_d, eng_y_q, eng_y_d;

    logic [31:0]          fifo_q [RES_DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                 fifo_full, push, pop;

    // ---------------- load side ----------------
    assign in_ready_o = !rst && !full_q[wr_bank_q];
    assign in_fire    = in_valid_i && in_ready_o;

    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        if (in_fire) begin
            if (wr_idx_q == IW'(VLEN - 1)) begin
                wr_idx_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
        // Fill and free always target different banks, so both may apply in one cycle.
        if (last_beat) full_d[rd_bank_q] = 1'b0;
    end

    // ---------------- issue FSM ----------------
    assign credit_ok  = (inflight_q < CW'(MAX_INFLIGHT)) &&
                        ((CW + 1)'(inflight_q) + (CW + 1)'(fifo_cnt_q) < (CW + 1)'(RES_DEPTH));
    assign last_beat  = (state_q == StBurst) && (beat_q == BW'(BEATS - 1));
    assign issue_idle = (state_q == StIdle) && full_q[rd_bank_q] && credit_ok;
    assign issue_next = last_beat && full_q[~rd_bank_q] && credit_ok;
    assign issue      = issue_idle || issue_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rd_bank_d = rd_bank_q;
        unique case (state_q)
            StIdle: begin
                if (issue_idle) begin
                    state_d = StBurst;
                    beat_d  = '0;
                end
            end
            StBurst: begin
                if (last_beat) begin
                    rd_bank_d = ~rd_bank_q;
                    beat_d    = '0;
                    state_d   = issue_next ? StBurst : StIdle;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign base_idx = IW'(beat_q) * IW'(LANES);

    always_comb begin
        eng_ready_d = 1'b0;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        if (state_q == StBurst) begin
            eng_ready_d = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                eng_x_d[32*k +: 32] = x_mem_q[rd_bank_q][base_idx + IW'(k)];
                eng_y_d[32*k +: 32] = y_mem_q[rd_bank_q][base_idx + IW'(k)];
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !eng_vld_i) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && eng_vld_i) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // ---------------- result FIFO ----------------
    assign fifo_full = (fifo_cnt_q == CW'(RES_DEPTH));
    assign push      = eng_vld_i && !fifo_full;
    assign pop       = res_valid_o && res_ack_i;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CW'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - CW'(1);
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            beat_q      <= '0;
            inflight_q  <= '0;
            eng_ready_q <= 1'b0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            beat_q      <= beat_d;
            inflight_q  <= inflight_d;
            eng_ready_q <= eng_ready_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < VLEN; i++) begin
                    x_mem_q[b][i] <= '0;
                    y_mem_q[b][i] <= '0;
                end
            end
            for (int i = 0; i < RES_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (in_fire) begin
                x_mem_q[wr_bank_q][wr_idx_q] <= in_x_i;
                y_mem_q[wr_bank_q][wr_idx_q] <= in_y_i;
            end
            if (push) fifo_q[wr_ptr_q] <= eng_z_i;
        end
    end

    // Outputs are forced quiet combinationally while rst is held.
    assign eng_ready_o = !rst && eng_ready_q;
    assign eng_x_o     = rst ? '0 : eng_x_q;
    assign eng_y_o     = rst ? '0 : eng_y_q;
    assign res_valid_o = !rst && (fifo_cnt_q != '0);
    assign res_data_o  = res_valid_o ? fifo_q[rd_ptr_q] : '0;

    fifo_overflow_a: assert property (@(posedge clk) disable iff (rst) !(eng_vld_i && fifo_full));

endmodule

// File: tb/tb_ddot_issue_ctrl.sv
// Bench for ddot_issue_ctrl: directed vector table, reset/credit corner sequences and a random
// run scored against a queue model plus a behavioural dot-product engine.
`timescale 1ns/1ps
module tb_ddot_issue_ctrl;
    localparam int LANES        = 4;
    localparam int VLEN         = 8;
    localparam int MAX_INFLIGHT = 3;
    localparam int RES_DEPTH    = 4;
    localparam int BEATS        = VLEN / LANES;
    localparam int LW           = LANES * 32;
    localparam int TMO          = 200;

    typedef logic [32*VLEN-1:0] vec_t;
    typedef struct {
        int unsigned x0;
        int unsigned xstep;
        int unsigned y;
        int          gap;
        logic [31:0] exp_z;
    } dvec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_x = '0, in_y = '0;
    logic          eng_ready;
    logic [LW-1:0] eng_x, eng_y;
    logic          eng_vld = 1'b0;
    logic [31:0]   eng_z = '0;
    logic          res_valid;
    logic [31:0]   res_data;
    logic          res_ack = 1'b0;

    int unsigned cyc = 0;
    int          n_vec = 0, n_err = 0;
    int          ack_mode = 0;
    int unsigned eng_lat_max = 4;

    // reference model state
    vec_t        ld_x, ld_y;
    int          ld_idx = 0;
    vec_t        exp_vx[$], exp_vy[$];
    logic [31:0] exp_res[$];
    vec_t        cur_ex, cur_ey, col_x, col_y;
    int          beat_cnt = 0, run_len = 0;
    int          inflight_m = 0, fifo_m = 0;
    logic        pop_prev = 1'b0, vld_prev = 1'b0;
    int          bursts_started = 0, results_popped = 0;
    int unsigned eng_due[$];
    logic [31:0] eng_val[$];
    int unsigned last_due = 0;

    ddot_issue_ctrl #(
        .LANES       (LANES),
        .VLEN        (VLEN),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .RES_DEPTH   (RES_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_x_i     (in_x),
        .in_y_i     (in_y),
        .eng_ready_o(eng_ready),
        .eng_x_o    (eng_x),
        .eng_y_o    (eng_y),
        .eng_vld_i  (eng_vld),
        .eng_z_i    (eng_z),
        .res_valid_o(res_valid),
        .res_data_o (res_data),
        .res_ack_i  (res_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact single-precision encoding of a non-negative integer below 2**24.
    function automatic logic [31:0] int2fp(input int unsigned n);
        int unsigned e;
        int unsigned m;
        if (n == 0) return 32'h0;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        m = n << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic int unsigned fp2int(input logic [31:0] f);
        int          e;
        int unsigned m;
        if (f[30:0] == 0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'd0, 1'b1, f[22:0]};
        return m >> (23 - e);
    endfunction

    function automatic logic [31:0] dot(input vec_t xs, input vec_t ys);
        int unsigned s = 0;
        for (int i = 0; i < VLEN; i++) s += fp2int(xs[32*i +: 32]) * fp2int(ys[32*i +: 32]);
        return int2fp(s);
    endfunction

    // Monitor: load model, burst scoreboard, behavioural engine capture, result scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ld_idx = 0; beat_cnt = 0; run_len = 0; inflight_m = 0; fifo_m = 0;
                pop_prev = 1'b0; vld_prev = 1'b0;
                exp_vx.delete(); exp_vy.delete(); exp_res.delete();
                continue;
            end
            if (pop_prev) fifo_m--;
            if (vld_prev) begin inflight_m--; fifo_m++; end
            if (in_valid && in_ready) begin
                ld_x[32*ld_idx +: 32] = in_x;
                ld_y[32*ld_idx +: 32] = in_y;
                ld_idx++;
                if (ld_idx == VLEN) begin
                    exp_vx.push_back(ld_x);
                    exp_vy.push_back(ld_y);
                    exp_res.push_back(dot(ld_x, ld_y));
                    ld_idx = 0;
                end
            end
            if (eng_ready) begin
                if (beat_cnt == 0) begin
                    inflight_m++;
                    bursts_started++;
                    check("credit_limit", LW'(inflight_m <= MAX_INFLIGHT &&
                                              inflight_m + fifo_m <= RES_DEPTH), 1);
                    check("burst_has_vector", LW'(exp_vx.size() != 0), 1);
                    if (exp_vx.size() != 0) begin
                        cur_ex = exp_vx.pop_front();
                        cur_ey = exp_vy.pop_front();
                    end
                end
                check("lanes_x", eng_x, cur_ex[beat_cnt*LW +: LW]);
                check("lanes_y", eng_y, cur_ey[beat_cnt*LW +: LW]);
                col_x[beat_cnt*LW +: LW] = eng_x;
                col_y[beat_cnt*LW +: LW] = eng_y;
                beat_cnt++;
                run_len++;
                if (beat_cnt == BEATS) begin
                    int unsigned due;
                    beat_cnt = 0;
                    due = cyc + $urandom_range(1, eng_lat_max);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    eng_due.push_back(due);
                    eng_val.push_back(dot(col_x, col_y));
                end
            end else if (run_len != 0) begin
                check("burst_len", LW'(run_len % BEATS), 0);
                run_len = 0;
            end
            check("res_valid", res_valid, LW'(fifo_m != 0));
            if (!res_valid) check("res_data_empty", res_data, 0);
            if (res_valid && res_ack) begin
                check("result_expected", LW'(exp_res.size() != 0), 1);
                if (exp_res.size() != 0) check("result", res_data, exp_res.pop_front());
                results_popped++;
            end
            pop_prev = res_valid && res_ack;
            vld_prev = eng_vld;
        end
    end

    // Engine return driver; returns z in issue order after a random latency.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                eng_vld = 1'b0;
                eng_due.delete(); eng_val.delete(); last_due = 0;
            end else if (eng_due.size() != 0 && eng_due[0] <= cyc) begin
                eng_vld = 1'b1;
                eng_z   = eng_val.pop_front();
                void'(eng_due.pop_front());
            end else begin
                eng_vld = 1'b0;
                eng_z   = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_mode == 2) res_ack = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_vec(input vec_t xs, input vec_t ys, input int gap, output int unsigned t_last);
        int g;
        t_last = cyc;
        for (int i = 0; i < VLEN; i++) begin
            in_valid = 1'b1;
            in_x = xs[32*i +: 32];
            in_y = ys[32*i +: 32];
            @(negedge clk);
            g = 0;
            while (!in_ready && g < TMO) begin @(negedge clk); g++; end
            if (!in_ready) begin
                check("src_accept", in_ready, 1);
                in_valid = 1'b0;
                step();
                return;
            end
            step();
            t_last = cyc;
            in_valid = 1'b0;
            if (gap == 1) step();
            else if (gap == 2) repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic rand_vec(output vec_t xs, output vec_t ys);
        for (int i = 0; i < VLEN; i++) begin
            xs[32*i +: 32] = int2fp($urandom_range(0, 15));
            ys[32*i +: 32] = int2fp($urandom_range(0, 15));
        end
    endtask

    task automatic drain(input string name);
        int g = 0;
        @(negedge clk);
        while ((exp_res.size() != 0 || fifo_m != 0 || exp_vx.size() != 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check(name, LW'(exp_res.size() + fifo_m + exp_vx.size()), 0);
        step();
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp_z);
        int g = 0;
        @(negedge clk);
        while (!res_valid && g < TMO) begin @(negedge clk); g++; end
        check({name, "_valid"}, res_valid, 1);
        check(name, res_data, exp_z);
        step();
    endtask

    initial begin
        dvec_t       tbl[4];
        vec_t        xs, ys;
        int unsigned tl;
        int          g, b0, p0;

        tbl[0] = '{x0: 1, xstep: 0, y: 2, gap: 0, exp_z: 32'h4180_0000};  // 16.0
        tbl[1] = '{x0: 1, xstep: 1, y: 1, gap: 1, exp_z: 32'h4210_0000};  // 36.0
        tbl[2] = '{x0: 2, xstep: 0, y: 3, gap: 0, exp_z: 32'h4240_0000};  // 48.0
        tbl[3] = '{x0: 1, xstep: 1, y: 2, gap: 1, exp_z: 32'h4290_0000};  // 72.0

        repeat (3) step();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_eng_ready", eng_ready, 0);
        check("rst_eng_x", eng_x, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_eng_ready", eng_ready, 0);
        step();

        // directed table: latency, lane order, held lanes, result value
        res_ack = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < VLEN; i++) begin
                xs[32*i +: 32] = int2fp(tbl[t].x0 + i * tbl[t].xstep);
                ys[32*i +: 32] = int2fp(tbl[t].y);
            end
            send_vec(xs, ys, tbl[t].gap, tl);
            g = 0;
            @(negedge clk);
            while (!eng_ready && g < 20) begin @(negedge clk); g++; end
            check("first_beat_latency", LW'(cyc - tl), 2);
            check("beat0_x", eng_x, xs[0 +: LW]);
            check("beat0_y", eng_y, ys[0 +: LW]);
            @(negedge clk);
            check("beat1_ready", eng_ready, 1);
            check("beat1_x", eng_x, xs[LW +: LW]);
            @(negedge clk);
            check("after_burst_ready", eng_ready, 0);
            check("after_burst_x_held", eng_x, xs[LW +: LW]);
            wait_result("table_z", tbl[t].exp_z);
        end

        // credit stall with no consumer, then drain
        eng_lat_max = 3;
        res_ack = 1'b0;
        b0 = bursts_started;
        p0 = results_popped;
        for (int v = 0; v < 6; v++) begin
            rand_vec(xs, ys);
            send_vec(xs, ys, 0, tl);
        end
        repeat (20) step();
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_eng_ready", eng_ready, 0);
        check("stall_res_valid", res_valid, 1);
        check("stall_bursts", LW'(bursts_started - b0), RES_DEPTH);
        step();
        res_ack = 1'b1;
        drain("stall_drain");
        check("stall_all_results", LW'(results_popped - p0), 6);

        // reset during beat 1 of a burst
        for (int i = 0; i < VLEN; i++) begin
            xs[32*i +: 32] = int2fp(i + 1);
            ys[32*i +: 32] = int2fp(1);
        end
        send_vec(xs, ys, 0, tl);
        g = 0;
        @(negedge clk);
        while (!eng_ready && g < 20) begin @(negedge clk); g++; end
        check("pre_rst_burst", eng_ready, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_eng_ready", eng_ready, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_eng_x", eng_x, 0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("after_midrst_in_ready", in_ready, 1);
        check("after_midrst_eng_ready", eng_ready, 0);
        step();
        for (int i = 0; i < VLEN; i++) begin
            xs[32*i +: 32] = int2fp(3);
            ys[32*i +: 32] = int2fp(1);
        end
        send_vec(xs, ys, 0, tl);
        wait_result("fresh_after_rst", 32'h41C0_0000);  // 24.0

        // randomized traffic against the model
        eng_lat_max = 8;
        ack_mode = 2;
        for (int v = 0; v < 30; v++) begin
            rand_vec(xs, ys);
            send_vec(xs, ys, 2, tl);
        end
        ack_mode = 0;
        res_ack = 1'b1;
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
